// File: rtl/alu.sv
// rtl/alu.sv - 16-bit ALU and 1-bit shifter sharing a tri-state result bus, with registered carry/zero flags
module alu #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    input  logic [4:0]       f,
    input  logic             csel,
    input  logic             ucin,
    input  logic             fcin,
    output logic             cout,
    output logic             zout,
    input  logic             notALUOE,
    input  logic             notShiftOE,
    output logic             carry_q,
    output logic             zero_q
);

    localparam logic [4:0] F_A           = 5'h00;
    localparam logic [4:0] F_B           = 5'h01;
    localparam logic [4:0] F_SUB         = 5'h02;
    localparam logic [4:0] F_ADD         = 5'h03;
    localparam logic [4:0] F_A_MINUS_ONE = 5'h04;
    localparam logic [4:0] F_ZERO        = 5'h05;
    localparam logic [4:0] F_NOT         = 5'h06;
    localparam logic [4:0] F_XOR         = 5'h07;
    localparam logic [4:0] F_AND         = 5'h08;
    localparam logic [4:0] F_OR          = 5'h09;

    logic             cin;
    logic [WIDTH:0]   cin_ext;
    logic [WIDTH:0]   a_ext;
    logic [WIDTH:0]   b_ext;
    logic [WIDTH:0]   alu_res;
    logic [WIDTH:0]   shift_res;
    logic [WIDTH:0]   sel_res;
    logic             alu_en;
    logic             shift_en;
    logic             drive;

    assign cin     = csel ? ucin : fcin;
    assign cin_ext = {{WIDTH{1'b0}}, cin};
    assign a_ext   = {1'b0, a};
    assign b_ext   = {1'b0, b};

    // Exactly one enable low selects a driver; both low is treated like both high so the bus never contends.
    assign alu_en   = !notALUOE && notShiftOE;
    assign shift_en = !notShiftOE && notALUOE;
    assign drive    = alu_en || shift_en;

    // Bit WIDTH of each result is the carry out.
    always_comb begin
        alu_res = '0;
        case (f)
            F_A:           alu_res = a_ext + cin_ext;
            F_B:           alu_res = b_ext;
            F_SUB:         alu_res = a_ext + {1'b0, ~b} + cin_ext;
            F_ADD:         alu_res = a_ext + b_ext + cin_ext;
            F_A_MINUS_ONE: alu_res = a_ext + {1'b0, {WIDTH{1'b1}}} + cin_ext;
            F_ZERO:        alu_res = '0;
            F_NOT:         alu_res = {1'b0, ~a};
            F_XOR:         alu_res = {1'b0, a ^ b};
            F_AND:         alu_res = {1'b0, a & b};
            F_OR:          alu_res = {1'b0, a | b};
            default:       alu_res = '0;
        endcase
    end

    always_comb begin
        shift_res = '0;
        if (f[0]) begin
            shift_res = {a[WIDTH-1], a[WIDTH-2:0], 1'b0};
        end else begin
            shift_res = {a[0], 1'b0, a[WIDTH-1:1]};
        end
    end

    always_comb begin
        sel_res = '0;
        if (alu_en) begin
            sel_res = alu_res;
        end else if (shift_en) begin
            sel_res = shift_res;
        end
    end

    assign y    = drive ? sel_res[WIDTH-1:0] : 'z;
    assign cout = drive && sel_res[WIDTH];
    assign zout = drive && (sel_res[WIDTH-1:0] == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else if (drive) begin
            carry_q <= cout;
            zero_q  <= zout;
        end
    end

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - randomized and directed self-checking bench for alu against an arithmetic reference model
module tb_alu;

    logic        clk;
    logic        reset;
    logic [15:0] a;
    logic [15:0] b;
    logic [4:0]  f;
    logic        csel;
    logic        ucin;
    logic        fcin;
    logic        notALUOE;
    logic        notShiftOE;
    tri1  [15:0] y;
    wire         cout;
    wire         zout;
    wire         carry_q;
    wire         zero_q;

    int n_checks;
    int n_pass;

    // Released bus floats to all ones through the pull-up, so an undriven bus reads FFFF here.
    localparam logic [15:0] BUS_IDLE = 16'hFFFF;

    alu dut (
        .clk        (clk),
        .reset      (reset),
        .a          (a),
        .b          (b),
        .y          (y),
        .f          (f),
        .csel       (csel),
        .ucin       (ucin),
        .fcin       (fcin),
        .cout       (cout),
        .zout       (zout),
        .notALUOE   (notALUOE),
        .notShiftOE (notShiftOE),
        .carry_q    (carry_q),
        .zero_q     (zero_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Returns {driven, cout, zout, y} computed with plain integer arithmetic.
    function automatic logic [18:0] model(input int fc, input int av, input int bv, input int cs,
                                          input int uc, input int fcn, input int nalu, input int nsh);
        int unsigned r;
        int unsigned c;
        int unsigned yy;
        int          ci;
        ci = cs ? uc : fcn;
        r  = 0;
        if (nalu == 0 && nsh == 1) begin
            case (fc)
                0: r = av + ci;
                1: r = bv;
                2: r = av + (65535 - bv) + ci;
                3: r = av + bv + ci;
                4: r = av + 65535 + ci;
                6: r = 65535 - av;
                7: r = av ^ bv;
                8: r = av & bv;
                9: r = av | bv;
                default: r = 0;
            endcase
        end else if (nsh == 0 && nalu == 1) begin
            if (fc % 2 == 1) r = av * 2;
            else             r = av / 2 + (av % 2) * 65536;
        end else begin
            return {1'b0, 1'b0, 1'b0, BUS_IDLE};
        end
        c  = r / 65536;
        yy = r % 65536;
        return {1'b1, c[0], (yy == 0), yy[15:0]};
    endfunction

    task automatic set_in(input logic [4:0] fi, input logic [15:0] ai, input logic [15:0] bi,
                          input logic cs, input logic uc, input logic fcn, input logic nalu, input logic nsh);
        f = fi; a = ai; b = bi; csel = cs; ucin = uc; fcin = fcn;
        notALUOE = nalu; notShiftOE = nsh;
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [15:0] ey, input logic ec, input logic ez);
        check({tag, ".y"}, {16'h0, y}, {16'h0, ey});
        check({tag, ".cout"}, {31'h0, cout}, {31'h0, ec});
        check({tag, ".zout"}, {31'h0, zout}, {31'h0, ez});
    endtask

    logic [18:0] m;
    logic        mc;
    logic        mz;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        set_in(5'h05, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        #2;
        check("reset.carry_q", {31'h0, carry_q}, 32'h0);
        check("reset.zero_q", {31'h0, zero_q}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        set_in(5'h00, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1); expect_out("pass_a_ffff", 16'h0000, 1'b1, 1'b1);
        set_in(5'h00, 16'hDEAD, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); expect_out("pass_a_dead", 16'hDEAD, 1'b0, 1'b0);
        set_in(5'h04, 16'hDEAD, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); expect_out("amo_dead", 16'hDEAC, 1'b1, 1'b0);
        set_in(5'h04, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); expect_out("amo_zero", 16'hFFFF, 1'b0, 1'b0);
        set_in(5'h03, 16'hA4D7, 16'h07F8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); expect_out("add_a4d7", 16'hACCF, 1'b0, 1'b0);
        set_in(5'h03, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); expect_out("add_wrap", 16'h0000, 1'b1, 1'b1);
        set_in(5'h03, 16'hF031, 16'h0010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1); expect_out("add_ucin", 16'hF042, 1'b0, 1'b0);
        set_in(5'h02, 16'hF000, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1); expect_out("sub_f000", 16'hEFFF, 1'b1, 1'b0);
        set_in(5'h02, 16'h0001, 16'h0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1); expect_out("sub_borrow", 16'hFFF1, 1'b0, 1'b0);
        set_in(5'h02, 16'hF000, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); expect_out("sub_cin0", 16'hEFEF, 1'b1, 1'b0);
        set_in(5'h05, 16'hxxxx, 16'hxxxx, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1); expect_out("zero_x", 16'h0000, 1'b0, 1'b1);
        set_in(5'h06, 16'hF031, 16'h0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1); expect_out("not", 16'h0FCE, 1'b0, 1'b0);
        set_in(5'h07, 16'hF031, 16'h0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1); expect_out("xor", 16'hF021, 1'b0, 1'b0);
        set_in(5'h08, 16'hF031, 16'h0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1); expect_out("and", 16'h0010, 1'b0, 1'b0);
        set_in(5'h09, 16'hF031, 16'h0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1); expect_out("or", 16'hF031, 1'b0, 1'b0);
        set_in(5'h01, 16'h0031, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); expect_out("shl_0031", 16'h0062, 1'b0, 1'b0);
        set_in(5'h01, 16'h8FA1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); expect_out("shl_8fa1", 16'h1F42, 1'b1, 1'b0);
        set_in(5'h01, 16'h8000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); expect_out("shl_8000", 16'h0000, 1'b1, 1'b1);
        set_in(5'h00, 16'hF031, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); expect_out("shr_f031", 16'h7818, 1'b1, 1'b0);
        set_in(5'h05, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1); expect_out("both_high", BUS_IDLE, 1'b0, 1'b0);
        set_in(5'h05, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); expect_out("both_low", BUS_IDLE, 1'b0, 1'b0);

        @(negedge clk);
        set_in(5'h03, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        check("reg_add.carry_q", {31'h0, carry_q}, 32'h1);
        check("reg_add.zero_q", {31'h0, zero_q}, 32'h1);
        @(negedge clk);
        set_in(5'h05, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        @(posedge clk); #1;
        check("reg_hold.carry_q", {31'h0, carry_q}, 32'h1);
        check("reg_hold.zero_q", {31'h0, zero_q}, 32'h1);
        @(negedge clk);
        set_in(5'h05, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("reg_illegal.carry_q", {31'h0, carry_q}, 32'h1);
        check("reg_illegal.zero_q", {31'h0, zero_q}, 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset.carry_q", {31'h0, carry_q}, 32'h0);
        check("async_reset.zero_q", {31'h0, zero_q}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        mc = 1'b0;
        mz = 1'b0;

        for (int i = 0; i < 400; i++) begin
            logic [1:0] en;
            @(negedge clk);
            en = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) en = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
            set_in(5'($urandom_range(0, 11)), 16'($urandom), 16'($urandom),
                   1'($urandom), 1'($urandom), 1'($urandom), en[1], en[0]);
            if ($urandom_range(0, 7) == 0) begin
                set_in(f, 16'hFFFF, 16'h0001, csel, ucin, fcin, notALUOE, notShiftOE);
            end
            m = model(int'(f), int'(a), int'(b), int'(csel), int'(ucin), int'(fcin),
                      int'(notALUOE), int'(notShiftOE));
            expect_out($sformatf("rnd%0d_f%0h_en%0b", i, f, en), m[15:0], m[17], m[16]);
            if (m[18]) begin
                mc = m[17];
                mz = m[16];
            end
            @(posedge clk); #1;
            check($sformatf("rnd%0d.carry_q", i), {31'h0, carry_q}, {31'h0, mc});
            check($sformatf("rnd%0d.zero_q", i), {31'h0, zero_q}, {31'h0, mz});
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
